regfile_mp: RTL and testbench

Parametrised multi-port register file for the multi-cycle and pipelined MIPS datapaths, generalising the single-write, two-read RegFile. It provides two asynchronous read ports and two synchronous write ports with fixed priority. It also offers optional same-cycle write-to-read bypass, a hard-wired zero register, and a per-register busy scoreboard that lets the control unit stall on pending multi-cycle results. It sits between decode (read addresses) and writeback (write ports), and the hazard unit consumes the busy outputs.

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 137 +++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two prioritised write
// ports, optional write-to-read bypass, hard-wired zero register and busy scoreboard.
module regfile_mp_rport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit BYPASS   = 1,
  parameter bit ZERO_REG = 1
) (
  input  logic [AW-1:0]               ra,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy,
  input  logic                        wv0,
  input  logic [AW-1:0]               wa0,
  input  logic [WIDTH-1:0]            wd0,
  input  logic                        wv1,
  input  logic [AW-1:0]               wa1,
  input  logic [WIDTH-1:0]            wd1,
  input  logic                        set_hit,
  output logic [WIDTH-1:0]            rd,
  output logic                        bsy
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic ok, hit0, hit1;

  // wv0/wv1 already exclude out-of-range and zero-register targets
  assign ok   = ({1'b0, ra} < (AW+1)'(DEPTH)) && !(ZERO_REG && ra == '0);
  assign hit1 = BYPASS && wv1 && (wa1 == ra);
  assign hit0 = BYPASS && wv0 && (wa0 == ra);

  always_comb begin
    rd  = '0;
    bsy = 1'b0;
    if (hit1)    rd = wd1;
    else if (hit0) rd = wd0;
    else if (ok) rd = regs[ra[IW-1:0]];
    // a completing write hides the busy bit unless a new producer claims it
    if (ok && !((hit0 || hit1) && !set_hit)) bsy = busy[ra[IW-1:0]];
  end
endmodule

module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit BYPASS   = 1,
  parameter bit ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             setBusy,
  input  logic [AW-1:0]    busyAddr,
  output logic             busy0,
  output logic             busy1
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;
  logic                        wv0, wv1, sv;
  logic [1:0][AW-1:0]          ra;
  logic [1:0][WIDTH-1:0]       rd;
  logic [1:0]                  bsy;

  assign wv0 = we0 && ({1'b0, wa0} < (AW+1)'(DEPTH)) && !(ZERO_REG && wa0 == '0);
  assign wv1 = we1 && ({1'b0, wa1} < (AW+1)'(DEPTH)) && !(ZERO_REG && wa1 == '0);
  assign sv  = setBusy && ({1'b0, busyAddr} < (AW+1)'(DEPTH)) &&
               !(ZERO_REG && busyAddr == '0);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(g);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[g] <= '0;
          busy[g] <= 1'b0;
        end else begin
          if (wv1 && wa1 == IDX)      regs[g] <= wd1;
          else if (wv0 && wa0 == IDX) regs[g] <= wd0;
          // set beats clear: a producer issued this cycle supersedes the completing one
          if (sv && busyAddr == IDX)  busy[g] <= 1'b1;
          else if ((wv1 && wa1 == IDX) || (wv0 && wa0 == IDX)) busy[g] <= 1'b0;
        end
      end
    end

    assign ra[0] = ra0;
    assign ra[1] = ra1;
    for (g = 0; g < 2; g++) begin : g_rport
      regfile_mp_rport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_rport (
        .ra(ra[g]), .regs(regs), .busy(busy),
        .wv0(wv0), .wa0(wa0), .wd0(wd0),
        .wv1(wv1), .wa1(wa1), .wd1(wd1),
        .set_hit(sv && busyAddr == ra[g]),
        .rd(rd[g]), .bsy(bsy[g])
      );
    end
  endgenerate

  assign rd0   = rd[0];
  assign rd1   = rd[1];
  assign busy0 = bsy[0];
  assign busy1 = bsy[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance share all inputs.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, setBusy;
  logic [4:0]  wa0, wa1, ra0, ra1, busyAddr;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1, nrd0, nrd1;
  logic        busy0, busy1, nbusy0, nbusy1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .setBusy(setBusy), .busyAddr(busyAddr), .busy0(busy0), .busy1(busy1)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(nrd0), .rd1(nrd1),
    .setBusy(setBusy), .busyAddr(busyAddr), .busy0(nbusy0), .busy1(nbusy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; setBusy = 0;
  endtask

  initial begin
    rst_n = 0; we0 = 0; we1 = 0; setBusy = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra0 = 3; ra1 = 31; busyAddr = 0;

    // reset held for two edges, then released
    tick(); tick();
    chk("rst_rd0", rd0, 0);
    chk("rst_busy0", {31'b0, busy0}, 0);
    rst_n = 1; #1;
    chk("rel_rd0", rd0, 0);
    chk("rel_rd1", rd1, 0);
    chk("rel_busy0", {31'b0, busy0}, 0);
    chk("rel_busy1", {31'b0, busy1}, 0);

    // write with bypass vs. without
    we0 = 1; wa0 = 3; wd0 = 45; ra0 = 3; #1;
    chk("byp_rd0_pre", rd0, 45);
    chk("nobyp_rd0_pre", nrd0, 0);
    tick(); idle(); #1;
    chk("byp_rd0_post", rd0, 45);
    chk("nobyp_rd0_post", nrd0, 45);

    // dual write to the same address: port 1 wins
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA; we1 = 1; wa1 = 7; wd1 = 32'h5555; ra1 = 7; #1;
    chk("coll_byp_pre", rd1, 32'h5555);
    tick(); idle(); #1;
    chk("coll_rd1", rd1, 32'h5555);
    chk("coll_nb_rd1", nrd1, 32'h5555);

    // zero register ignores writes and busy sets
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; setBusy = 1; busyAddr = 0; ra0 = 0; #1;
    chk("zero_rd0_pre", rd0, 0);
    chk("zero_busy0_pre", {31'b0, busy0}, 0);
    tick(); idle(); #1;
    chk("zero_rd0", rd0, 0);
    chk("zero_nb_rd0", nrd0, 0);
    chk("zero_busy0", {31'b0, busy0}, 0);
    tick();
    chk("zero_rd0_later", rd0, 0);

    // scoreboard
    setBusy = 1; busyAddr = 9; ra0 = 9; #1;
    chk("sb_busy0_pre", {31'b0, busy0}, 0);
    tick(); idle(); #1;
    chk("sb_busy0_set", {31'b0, busy0}, 1);
    chk("sb_nb_busy0_set", {31'b0, nbusy0}, 1);
    we1 = 1; wa1 = 9; wd1 = 12; #1;
    chk("sb_byp_busy0", {31'b0, busy0}, 0);
    chk("sb_byp_rd0", rd0, 12);
    chk("sb_nb_busy0", {31'b0, nbusy0}, 1);
    chk("sb_nb_rd0", nrd0, 0);
    tick(); idle(); #1;
    chk("sb_busy0_clr", {31'b0, busy0}, 0);
    chk("sb_rd0", rd0, 12);
    setBusy = 1; busyAddr = 9; we0 = 1; wa0 = 9; wd0 = 77; #1;
    chk("sb_both_busy_pre", {31'b0, busy0}, 0);
    chk("sb_both_rd_pre", rd0, 77);
    tick(); idle(); #1;
    chk("sb_both_busy0", {31'b0, busy0}, 1);
    chk("sb_both_rd0", rd0, 77);
    chk("sb_both_nb_busy0", {31'b0, nbusy0}, 1);

    // port priority on bypass: both write different data, port 1 address read
    we0 = 1; wa0 = 1; wd0 = 32'h11; we1 = 1; wa1 = 2; wd1 = 32'h22; ra0 = 1; ra1 = 2; #1;
    chk("pair_byp_rd0", rd0, 32'h11);
    chk("pair_byp_rd1", rd1, 32'h22);
    tick();
    we0 = 1; wa0 = 3; wd0 = 32'h33; we1 = 1; wa1 = 4; wd1 = 32'h44;
    setBusy = 1; busyAddr = 2;
    tick(); idle(); ra0 = 2; ra1 = 4; #1;
    chk("pre_rst_rd0", rd0, 32'h22);
    chk("pre_rst_rd1", rd1, 32'h44);
    chk("pre_rst_busy0", {31'b0, busy0}, 1);

    // asynchronous reset between edges
    rst_n = 0; #1;
    chk("arst_rd0", rd0, 0);
    chk("arst_rd1", rd1, 0);
    chk("arst_busy0", {31'b0, busy0}, 0);
    chk("arst_nb_rd1", nrd1, 0);
    ra0 = 1; ra1 = 3; #1;
    chk("arst_rd0_r1", rd0, 0);
    chk("arst_rd1_r3", rd1, 0);
    tick();
    rst_n = 1; #1;
    chk("post_rst_rd1", rd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
